uart_image_loader: RTL and testbench

//  Downstream of the UART byte receiver. Frames the received byte stream into one
//  IMG_W x IMG_H 8-bit grayscale image and writes it row-major into the pixel RAM.

---
 rtl/uart_image_loader_if.sv | 33 +++
 rtl/uart_image_loader.sv | 138 +++++++++++++
 tb/tb_uart_image_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_image_loader_if.sv
// uart_image_loader_if
//   Bundles the byte-receive handshake, the detector hand-back strobe and the
//   pixel-RAM write bus of the image loader into one port.
//   master : byte source / detector side. Drives uart_data_rdy, uart_data and
//            img_consumed. Observes everything else.
//   slave  : the loader. Drives the RAM write bus, img_ready, frame_err,
//            overrun and fpga_can_receive.
interface uart_image_loader_if #(
    parameter int ADDR_W = 10
);
    logic              uart_data_rdy;
    logic [7:0]        uart_data;
    logic              img_consumed;
    logic              fpga_can_receive;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic              img_ready;
    logic              frame_err;
    logic              overrun;

    modport master (
        output uart_data_rdy, uart_data, img_consumed,
        input  fpga_can_receive, pix_we, pix_addr, pix_data,
               img_ready, frame_err, overrun
    );

    modport slave (
        input  uart_data_rdy, uart_data, img_consumed,
        output fpga_can_receive, pix_we, pix_addr, pix_data,
               img_ready, frame_err, overrun
    );
endinterface

// File: rtl/uart_image_loader.sv
// uart_image_loader
//   Frames the UART byte stream into one IMG_W x IMG_H grayscale image.
//   A SYNC_BYTE seen while idle opens a frame. The next IMG_W*IMG_H bytes are
//   written row-major to the pixel RAM, one cycle after each strobe. The image
//   is then held, with img_ready high and fpga_can_receive low, until the
//   detector returns img_consumed. A frame that stalls for TIMEOUT_CYC cycles
//   is aborted and frame_err pulses for one cycle.
// Ports
//   clock : system clock
//   reset : synchronous reset, active low
//   bus   : uart_image_loader_if.slave, which carries the byte input, the
//           consumed strobe, the RAM write bus and the status outputs
// All outputs come straight from registers.
module uart_image_loader #(
    parameter int          IMG_W       = 24,
    parameter int          IMG_H       = 24,
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 500000
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_image_loader_if.slave   bus
);
    localparam int N     = IMG_W * IMG_H;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t            r_state,     w_state_nx;
    logic [ADDR_W-1:0] r_index,     w_index_nx;
    logic [TMR_W-1:0]  r_timer,     w_timer_nx;
    logic              r_pix_we,    w_pix_we_nx;
    logic [ADDR_W-1:0] r_pix_addr,  w_pix_addr_nx;
    logic [7:0]        r_pix_data,  w_pix_data_nx;
    logic              r_img_ready, w_img_ready_nx;
    logic              r_frame_err, w_frame_err_nx;
    logic              r_overrun,   w_overrun_nx;
    logic              r_can_rx,    w_can_rx_nx;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_timer     <= '0;
            r_pix_we    <= 1'b0;
            r_pix_addr  <= '0;
            r_pix_data  <= '0;
            r_img_ready <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_can_rx    <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_index     <= w_index_nx;
            r_timer     <= w_timer_nx;
            r_pix_we    <= w_pix_we_nx;
            r_pix_addr  <= w_pix_addr_nx;
            r_pix_data  <= w_pix_data_nx;
            r_img_ready <= w_img_ready_nx;
            r_frame_err <= w_frame_err_nx;
            r_overrun   <= w_overrun_nx;
            r_can_rx    <= w_can_rx_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_index_nx     = r_index;
        w_timer_nx     = r_timer;
        w_pix_we_nx    = 1'b0;
        w_pix_addr_nx  = r_pix_addr;
        w_pix_data_nx  = r_pix_data;
        w_img_ready_nx = r_img_ready;
        w_frame_err_nx = 1'b0;
        w_overrun_nx   = r_overrun;
        w_can_rx_nx    = r_can_rx;

        unique case (r_state)
            IDLE: begin
                if (bus.uart_data_rdy && bus.uart_data == SYNC_BYTE) begin
                    w_state_nx   = LOAD;
                    w_index_nx   = '0;
                    w_timer_nx   = '0;
                    w_overrun_nx = 1'b0;
                end
            end
            LOAD: begin
                // A strobe takes priority over the timeout check, so a byte
                // that arrives in the last allowed cycle is still written.
                if (bus.uart_data_rdy) begin
                    w_pix_we_nx   = 1'b1;
                    w_pix_addr_nx = r_index;
                    w_pix_data_nx = bus.uart_data;
                    w_timer_nx    = '0;
                    if (r_index == LAST_IDX) begin
                        // img_ready and the RTS drop register together with
                        // the final write.
                        w_state_nx     = FULL;
                        w_index_nx     = '0;
                        w_img_ready_nx = 1'b1;
                        w_can_rx_nx    = 1'b0;
                    end else begin
                        w_index_nx = r_index + 1'b1;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_state_nx     = IDLE;
                    w_index_nx     = '0;
                    w_timer_nx     = '0;
                    w_frame_err_nx = 1'b1;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            FULL: begin
                // A byte arriving here is dropped. This also holds in the
                // release cycle, where the byte is not checked for sync.
                if (bus.uart_data_rdy) w_overrun_nx = 1'b1;
                if (bus.img_consumed) begin
                    w_state_nx     = IDLE;
                    w_img_ready_nx = 1'b0;
                    w_can_rx_nx    = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.pix_we           = r_pix_we;
    assign bus.pix_addr         = r_pix_addr;
    assign bus.pix_data         = r_pix_data;
    assign bus.img_ready        = r_img_ready;
    assign bus.frame_err        = r_frame_err;
    assign bus.overrun          = r_overrun;
    assign bus.fpga_can_receive = r_can_rx;
endmodule

// File: tb/tb_uart_image_loader.sv
// tb_uart_image_loader
//   Drives a directed byte sequence into uart_image_loader and checks the RAM
//   write bus and the status outputs against hand-computed values.
//   Inputs change 1 time unit after a rising edge. Outputs are checked at the
//   same point, which reflects the edge that has just occurred.
module tb_uart_image_loader;
    localparam int ADDR_W = 10;
    localparam int TMO    = 40;
    localparam int N      = 24 * 24;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    uart_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_image_loader #(
        .IMG_W(24), .IMG_H(24), .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One-cycle strobe. On return the edge that sampled it has occurred.
    task automatic send(input logic [7:0] b);
        bus.uart_data_rdy = 1'b1;
        bus.uart_data     = b;
        step();
        bus.uart_data_rdy = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    32'(bus.pix_we), 0);
        chk({tag, "_addr"},  32'(bus.pix_addr), 0);
        chk({tag, "_data"},  32'(bus.pix_data), 0);
        chk({tag, "_rdy"},   32'(bus.img_ready), 0);
        chk({tag, "_ferr"},  32'(bus.frame_err), 0);
        chk({tag, "_ovr"},   32'(bus.overrun), 0);
        chk({tag, "_canrx"}, 32'(bus.fpga_can_receive), 1);
    endtask

    initial begin
        bus.uart_data_rdy = 1'b0;
        bus.uart_data     = 8'h00;
        bus.img_consumed  = 1'b0;

        // 1: reset held for two cycles
        reset = 1'b0;
        step(); step();
        chk_reset_vals("rst");
        reset = 1'b1;
        step();

        // 2: a non-sync byte is ignored, then sync and a full frame
        send(8'h11);
        chk("junk_we", 32'(bus.pix_we), 0);
        send(8'hA5);
        chk("sync_we", 32'(bus.pix_we), 0);
        for (int i = 0; i < N; i++) begin
            send(8'(i % 256));
            chk("f_we",    32'(bus.pix_we), 1);
            chk("f_addr",  32'(bus.pix_addr), 32'(i));
            chk("f_data",  32'(bus.pix_data), 32'(i % 256));
            chk("f_rdy",   32'(bus.img_ready), (i == N - 1) ? 1 : 0);
            chk("f_canrx", 32'(bus.fpga_can_receive), (i == N - 1) ? 0 : 1);
            step();
            chk("f_we_off", 32'(bus.pix_we), 0);
        end

        // 3: a byte while FULL is dropped and sets overrun
        send(8'h33);
        chk("full_we",  32'(bus.pix_we), 0);
        chk("full_ovr", 32'(bus.overrun), 1);
        chk("full_rdy", 32'(bus.img_ready), 1);
        bus.img_consumed = 1'b1;
        step();
        bus.img_consumed = 1'b0;
        chk("cons_rdy",   32'(bus.img_ready), 0);
        chk("cons_canrx", 32'(bus.fpga_can_receive), 1);
        chk("cons_ovr",   32'(bus.overrun), 1);
        send(8'hA5);
        chk("ovr_clr",  32'(bus.overrun), 0);
        chk("sync2_we", 32'(bus.pix_we), 0);

        // 4: ten pixels, then silence until the timeout fires
        for (int i = 0; i < 10; i++) send(8'(8'h40 + i));
        chk("t_addr9", 32'(bus.pix_addr), 9);
        for (int k = 1; k < TMO; k++) step();
        chk("t_ferr_pre", 32'(bus.frame_err), 0);
        step();
        chk("t_ferr",     32'(bus.frame_err), 1);
        step();
        chk("t_ferr_off", 32'(bus.frame_err), 0);
        send(8'h07);
        chk("t_idle_we", 32'(bus.pix_we), 0);

        // 5: a new frame starts at address 0. A sync value mid-frame is data.
        send(8'hA5);
        send(8'h01);
        chk("r_we",   32'(bus.pix_we), 1);
        chk("r_addr", 32'(bus.pix_addr), 0);
        for (int i = 1; i < 5; i++) send(8'(i));
        send(8'hA5);
        chk("mid_we",   32'(bus.pix_we), 1);
        chk("mid_addr", 32'(bus.pix_addr), 5);
        chk("mid_data", 32'(bus.pix_data), 32'h000000A5);
        // A strobe in the timeout cycle wins.
        for (int k = 1; k < TMO; k++) step();
        send(8'h5C);
        chk("edge_we",   32'(bus.pix_we), 1);
        chk("edge_addr", 32'(bus.pix_addr), 6);
        chk("edge_ferr", 32'(bus.frame_err), 0);
        step();
        chk("edge_ferr2", 32'(bus.frame_err), 0);

        // 6: reset in the middle of a frame
        for (int i = 7; i < 300; i++) send(8'(i));
        chk("p299_addr", 32'(bus.pix_addr), 299);
        reset = 1'b0;
        step();
        chk_reset_vals("mid_rst");
        reset = 1'b1;
        send(8'hA5);
        send(8'h9E);
        chk("rs_addr", 32'(bus.pix_addr), 0);
        chk("rs_data", 32'(bus.pix_data), 32'h9E);

        // Release that coincides with a sync-valued byte: the byte is dropped
        // and overrun is set, so no frame opens.
        for (int i = 1; i < N; i++) send(8'(i));
        chk("f2_rdy", 32'(bus.img_ready), 1);
        bus.img_consumed  = 1'b1;
        bus.uart_data_rdy = 1'b1;
        bus.uart_data     = 8'hA5;
        step();
        bus.img_consumed  = 1'b0;
        bus.uart_data_rdy = 1'b0;
        chk("cs_rdy",   32'(bus.img_ready), 0);
        chk("cs_ovr",   32'(bus.overrun), 1);
        chk("cs_canrx", 32'(bus.fpga_can_receive), 1);
        send(8'h22);
        chk("cs_we", 32'(bus.pix_we), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
